// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Holds FSM states, the buffered character record and oversampling points.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    localparam logic [1:0] WLEN_5 = 2'b00;
    localparam logic [1:0] WLEN_6 = 2'b01;
    localparam logic [1:0] WLEN_7 = 2'b10;
    localparam logic [1:0] WLEN_8 = 2'b11;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_SAMPLE = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_SAMPLE = 4'(OVERSAMPLE - 1);

    // Index of the final data bit for a given word-length code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wlen);
        case (wlen)
            WLEN_5:  return 3'd4;
            WLEN_6:  return 3'd5;
            WLEN_7:  return 3'd6;
            WLEN_8:  return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous character buffer with registered valid and overrun pulse.
// Valid is registered so it trails a write by one clock.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             wb_clock,
    input  logic             wb_rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_valid;
    logic             r_overrun;

    logic [AW:0]      w_count;
    logic [AW:0]      w_count_left;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;

    assign w_count      = r_wptr - r_rptr;
    assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop        = r_valid && i_ready;
    assign w_wr         = i_push && (!w_full || w_pop);
    assign w_drop       = i_push && w_full && !w_pop;
    assign w_count_left = w_count - {{AW{1'b0}}, w_pop};

    always_ff @(posedge wb_clock) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge wb_clock or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Ignores this cycle's write so valid lags the write by a clock.
            r_valid   <= (w_count_left != '0);
            r_overrun <= w_drop;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_valid ? r_mem[r_rptr[AW-1:0]] : '0;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_serial_rx.sv
// 16x oversampling UART receiver: synchroniser, tick generator, deframing FSM.
// Characters with parity/framing/break status are queued in uart_rx_fifo.
//
// state  | meaning
// IDLE   | waiting for a falling edge; re-armed only after line seen high
// START  | validating start bit at mid-bit
// DATA   | sampling data bits LSB first
// PARITY | sampling and checking the parity bit
// STOP   | sampling stop bit, then queueing the character
module uart_serial_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 wb_clock,
    input  logic                 wb_rst_ni,
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    input  logic [1:0]           wlen_i,
    input  logic                 parity_en_i,
    input  logic                 parity_even_i,
    input  logic                 parity_stick_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [7:0]           out_data_o,
    output logic                 out_perr_o,
    output logic                 out_ferr_o,
    output logic                 out_brk_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [DIV_WIDTH-1:0] r_tick_cnt;
    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [3:0]           r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_par_acc;
    logic                 r_perr;
    logic                 r_all_zero;
    logic                 r_armed;
    logic [1:0]           r_wlen;
    logic                 r_par_en;
    logic                 r_par_even;
    logic                 r_par_stick;
    logic                 r_push;
    rx_entry_t            r_entry;
    rx_entry_t            w_head;
    logic                 w_en;
    logic                 w_tick;
    logic                 w_bit_pt;
    logic [7:0]           w_data_aligned;

    always_ff @(posedge wb_clock or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_en   = (divisor_i != '0);
    assign w_tick = w_en && (r_tick_cnt == '0);

    always_ff @(posedge wb_clock or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_tick_cnt <= '0;
        end else if (!w_en) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= divisor_i - DIV_WIDTH'(1);
        end else begin
            r_tick_cnt <= r_tick_cnt - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge wb_clock or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_en) begin
            w_state_next = IDLE;
        end else if (w_tick) begin
            case (r_state)
                IDLE:   if (r_armed && !r_rx_sync) w_state_next = START;
                START:  if (r_cnt == MID_SAMPLE) w_state_next = r_rx_sync ? IDLE : DATA;
                DATA:   if (r_cnt == BIT_SAMPLE && r_bit_idx == last_bit_idx(r_wlen))
                            w_state_next = r_par_en ? PARITY : STOP;
                PARITY: if (r_cnt == BIT_SAMPLE) w_state_next = STOP;
                STOP:   if (r_cnt == BIT_SAMPLE) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o   = (r_state != IDLE);
        w_bit_pt = w_tick && (r_cnt == BIT_SAMPLE);
    end

    // Bits were shifted in from the top, so short words sit high in r_shift.
    assign w_data_aligned = r_shift >> (3'd7 - last_bit_idx(r_wlen));

    always_ff @(posedge wb_clock or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_perr      <= 1'b0;
            r_all_zero  <= 1'b0;
            r_armed     <= 1'b0;
            r_wlen      <= '0;
            r_par_en    <= 1'b0;
            r_par_even  <= 1'b0;
            r_par_stick <= 1'b0;
            r_push      <= 1'b0;
            r_entry     <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_state == IDLE && r_rx_sync) begin
                r_armed <= 1'b1;
            end
            if (!w_en) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                        if (r_armed && !r_rx_sync) begin
                            r_armed <= 1'b0;
                        end
                    end
                    START: begin
                        if (r_cnt == MID_SAMPLE) begin
                            r_cnt <= '0;
                            if (!r_rx_sync) begin
                                r_wlen      <= wlen_i;
                                r_par_en    <= parity_en_i;
                                r_par_even  <= parity_even_i;
                                r_par_stick <= parity_stick_i;
                                r_bit_idx   <= '0;
                                r_shift     <= '0;
                                r_par_acc   <= 1'b0;
                                r_perr      <= 1'b0;
                                r_all_zero  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_bit_pt) begin
                            r_shift    <= {r_rx_sync, r_shift[7:1]};
                            r_par_acc  <= r_par_acc ^ r_rx_sync;
                            r_all_zero <= r_all_zero & ~r_rx_sync;
                            r_bit_idx  <= r_bit_idx + 3'd1;
                        end
                    end
                    PARITY: begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_bit_pt) begin
                            r_perr <= r_par_stick ? (r_rx_sync != ~r_par_even)
                                                  : ((r_par_acc ^ r_rx_sync) != ~r_par_even);
                            r_all_zero <= r_all_zero & ~r_rx_sync;
                        end
                    end
                    STOP: begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_bit_pt) begin
                            r_push       <= 1'b1;
                            r_entry.data <= w_data_aligned;
                            r_entry.perr <= r_perr;
                            r_entry.ferr <= ~r_rx_sync;
                            r_entry.brk  <= r_all_zero & ~r_rx_sync;
                        end
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wb_clock  (wb_clock),
        .wb_rst_ni (wb_rst_ni),
        .i_push    (r_push),
        .i_data    (r_entry),
        .i_ready   (out_ready_i),
        .o_valid   (out_valid_o),
        .o_data    (w_head),
        .o_overrun (overrun_o)
    );

    assign out_data_o = w_head.data;
    assign out_perr_o = w_head.perr;
    assign out_ferr_o = w_head.ferr;
    assign out_brk_o  = w_head.brk;

endmodule
